// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: default bubble instruction and stage states.
package pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload register (valid, data, ctrl, instr) with load, clear-to-bubble and masked outputs.
// Load and clear take effect at the next edge; clear wins over load. No handshake of its own.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          DATA_WIDTH = 69,
    parameter int          CTRL_WIDTH = 16,
    parameter logic [31:0] NOP_INSTR  = RV_NOP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [31:0]           i_instr,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [31:0]           o_instr
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [31:0]           r_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
            r_instr <= i_instr;
        end
    end

    // A bubble must never look like a real instruction downstream, whatever the register holds.
    assign o_valid = r_valid;
    assign o_data  = r_valid ? r_data  : '0;
    assign o_ctrl  = r_valid ? r_ctrl  : '0;
    assign o_instr = r_valid ? r_instr : NOP_INSTR;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline stage register with valid/ready handshake, optional skid slot and flush-to-bubble.
// Latency 1 cycle; SKID=1 gives a registered up_ready_o, SKID=0 a combinational one.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int          DATA_WIDTH = 69,
    parameter int          CTRL_WIDTH = 16,
    parameter logic [31:0] NOP_INSTR  = RV_NOP,
    parameter int          SKID       = 1,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    input  logic [CTRL_WIDTH-1:0] up_ctrl_i,
    input  logic [31:0]           up_instr_i,
    input  logic                  flush_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    output logic [CTRL_WIDTH-1:0] dn_ctrl_o,
    output logic [31:0]           dn_instr_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam logic [1:0] S_EMPTY = ST_EMPTY;
    localparam logic [1:0] S_FULL  = ST_FULL;
    localparam logic [1:0] S_SKID  = ST_SKID;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic                  w_up_xfer;
    logic                  w_dn_xfer;
    logic                  w_main_load;
    logic                  w_main_clear;
    logic                  w_from_skid;
    logic                  w_main_valid_in;
    logic [DATA_WIDTH-1:0] w_main_data_in;
    logic [CTRL_WIDTH-1:0] w_main_ctrl_in;
    logic [31:0]           w_main_instr_in;
    logic                  w_skid_valid;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic [CTRL_WIDTH-1:0] w_skid_ctrl;
    logic [31:0]           w_skid_instr;

    assign w_up_xfer = up_valid_i & up_ready_o;
    assign w_dn_xfer = dn_valid_o & dn_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_up_xfer) w_state_nxt = S_FULL;
                S_FULL: begin
                    if (w_up_xfer && !w_dn_xfer)      w_state_nxt = S_SKID;
                    else if (!w_up_xfer && w_dn_xfer) w_state_nxt = S_EMPTY;
                end
                S_SKID:  if (w_dn_xfer) w_state_nxt = S_FULL;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // With SKID=0 an up-transfer while full always coincides with a down-transfer, so one rule covers both.
    assign w_from_skid     = (r_state == S_SKID);
    assign w_main_load     = !flush_i && ((w_up_xfer && (r_state == S_EMPTY || w_dn_xfer)) ||
                                          (w_from_skid && w_dn_xfer));
    assign w_main_clear    = flush_i || (r_state == S_FULL && w_dn_xfer && !w_up_xfer);
    assign w_main_valid_in = w_from_skid ? w_skid_valid : 1'b1;
    assign w_main_data_in  = w_from_skid ? w_skid_data  : up_data_i;
    assign w_main_ctrl_in  = w_from_skid ? w_skid_ctrl  : up_ctrl_i;
    assign w_main_instr_in = w_from_skid ? w_skid_instr : up_instr_i;

    pipe_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_valid (w_main_valid_in),
        .i_data  (w_main_data_in),
        .i_ctrl  (w_main_ctrl_in),
        .i_instr (w_main_instr_in),
        .o_valid (dn_valid_o),
        .o_data  (dn_data_o),
        .o_ctrl  (dn_ctrl_o),
        .o_instr (dn_instr_o)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .CTRL_WIDTH (CTRL_WIDTH),
            .NOP_INSTR  (NOP_INSTR)
        ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (!flush_i && r_state == S_FULL && w_up_xfer && !w_dn_xfer),
            .i_clear (flush_i || (w_from_skid && w_dn_xfer)),
            .i_valid (1'b1),
            .i_data  (up_data_i),
            .i_ctrl  (up_ctrl_i),
            .i_instr (up_instr_i),
            .o_valid (w_skid_valid),
            .o_data  (w_skid_data),
            .o_ctrl  (w_skid_ctrl),
            .o_instr (w_skid_instr)
        );
        // Decoded straight from the state register: no path from dn_ready_i.
        assign up_ready_o = (r_state != S_SKID);
    end else begin : g_noskid
        assign w_skid_valid = 1'b0;
        assign w_skid_data  = '0;
        assign w_skid_ctrl  = '0;
        assign w_skid_instr = NOP_INSTR;
        assign up_ready_o   = !dn_valid_o || dn_ready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (dn_valid_o && !dn_ready_i && r_stall_cnt != {CNT_WIDTH{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised, elastic pipeline stage register for the CPU core. It replaces the fixed always-load stage registers, such as MEM→WB, with a single block that adds three things: a valid/ready handshake, an optional skid buffer, and flush-to-bubble. Every inter-stage boundary (Q1Q2…Q4Q5) instantiates it with its own payload width. A saturating stall counter is provided for performance analysis.

## Interface
Parameters:
- DATA_WIDTH, 69, datapath payload width (e.g. alu_out 32 + mem_rdata 32 + rd 5 for MEM→WB)
- CTRL_WIDTH, 16, control-bundle width
- NOP_INSTR, 32'h00000013, instruction word presented while the stage holds a bubble
- SKID, 1, 1 = two-entry skid buffer (registered up_ready_o); 0 = single entry (combinational up_ready_o)
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- up_valid_i  input  1  upstream payload valid
- up_ready_o  output  1  stage can accept this cycle
- up_data_i  input  DATA_WIDTH  upstream datapath payload
- up_ctrl_i  input  CTRL_WIDTH  upstream control bundle
- up_instr_i  input  32  upstream instruction word
- flush_i  input  1  synchronous flush; discard all contents
- dn_valid_o  output  1  downstream payload valid
- dn_ready_i  input  1  downstream accepts
- dn_data_o  output  DATA_WIDTH  downstream datapath payload
- dn_ctrl_o  output  CTRL_WIDTH  downstream control bundle
- dn_instr_o  output  32  downstream instruction word
- stall_cnt_o  output  CNT_WIDTH  cycles with dn_valid_o=1 and dn_ready_i=0

## Operation
- Transfer definitions:
  - Up-transfer: up_valid_i & up_ready_o at a rising edge.
  - Down-transfer: dn_valid_o & dn_ready_i at a rising edge.
- Storage:
  - Main slot drives the dn_* outputs.
  - Skid slot exists only when SKID=1.
- State machine for SKID=1:
  - EMPTY: up-transfer → FULL (main ← up).
  - FULL:
    - Up-transfer and down-transfer → FULL (main ← up).
    - Up-transfer only → SKID (skid ← up).
    - Down-transfer only → EMPTY.
  - SKID: down-transfer → FULL (main ← skid, skid cleared). up_ready_o=0.
- up_ready_o for SKID=1 is (state != SKID). It is registered and has no combinational path from dn_ready_i.
- SKID=0: states are EMPTY/FULL only.
  - up_ready_o = !dn_valid_o | dn_ready_i (combinational).
  - Up-transfer loads main.
  - A down-transfer with no up-transfer → EMPTY.
- Bubble masking: whenever dn_valid_o=0, the outputs are dn_data_o=0, dn_ctrl_o=0 and dn_instr_o=NOP_INSTR. A bubble can never write the register file or memory.
- Flush has priority over every other event.
  - Next state is EMPTY and both slots are cleared to bubble values.
  - An up-transfer in the same cycle is discarded.
  - stall_cnt_o is not affected.
- Stall counter:
  - Increments each cycle with dn_valid_o=1 & dn_ready_i=0.
  - Saturates at all-ones.
  - Cleared only by reset.

## Timing
- Reset values:
  - State EMPTY.
  - dn_valid_o=0, dn_data_o=0, dn_ctrl_o=0, dn_instr_o=NOP_INSTR, stall_cnt_o=0.
  - up_ready_o=1 for both SKID settings.
- Latency: the dn_* outputs show the up-transfer payload in the cycle after the accepting edge.
- Throughput: one transfer per cycle sustained while dn_ready_i=1.
- Payload ordering is strict FIFO. No duplication, no loss except by flush.
- SKID=1: up_ready_o falls the cycle after entering SKID and rises the cycle after the draining down-transfer.
- Holding: the dn_* outputs are stable while dn_valid_o=1 and dn_ready_i=0.
- Reset asserted mid-operation: immediate return to reset values; any in-flight payload is lost.

## Structure
- Shared package pipe_pkg holds:
  - RV_NOP constant (32'h00000013), used as the default NOP_INSTR.
  - The state enum {EMPTY, FULL, SKID}.
- Sub-module pipe_slot: one payload register (data, ctrl, instr, valid) with load, clear-to-bubble and bubble-masking outputs. It is instantiated once for main, and once more for skid when SKID=1.
- The FSM and stall counter live in pipe_stage.

## Test plan
- Reset: assert rst_n=0 mid-stream → dn_valid_o=0, dn_instr_o=32'h00000013, dn_ctrl_o=0, stall_cnt_o=0, up_ready_o=1.
- Streaming (SKID=1): up_valid_i held 1 with payloads 1..8, dn_ready_i=1 → dn_data_o emits 1..8 on consecutive cycles, one cycle late.
- Backpressure: drive dn_ready_i=0 for 3 cycles while payloads A, B, C arrive.
  - The stage holds A, skids B, and up_ready_o drops; C is held upstream.
  - Release → A, B, C in order.
  - stall_cnt_o=3.
- Flush: flush_i=1 in SKID state with up_valid_i=1 → the next cycle is EMPTY, dn_valid_o=0, NOP on dn_instr_o, and none of the three payloads (main, skid, incoming) appears.
- SKID=0: dn_ready_i=0 for one cycle → up_ready_o=0 combinationally in that cycle; a simultaneous down-transfer and up-transfer replaces main with no bubble.
- Saturation (CNT_WIDTH=4): 20 stalled cycles → stall_cnt_o=4'hF and it stays there.
